data_bus_responder: RTL
=======================

# data_bus_responder

Responder end of the CPU data bus: decodes each byte address the CPU drives and serves it from on-chip data RAM or a small memory-mapped I/O region. Reads are combinational so the single-cycle CPU can complete loads in one cycle. Writes commit on the clock edge. The I/O region holds an LED register, a free-running cycle counter, and a 4-entry transmit FIFO drained through a valid/ready handshake.

## Interface
Parameters:
- ADDR_WIDTH, 16, byte-address width of the data bus.
- DATA_WIDTH, 32, data word width.
- RAM_WORDS, 1024, data RAM depth in words (power of two, ≤ 2^(ADDR_WIDTH-3)).
- TX_DEPTH, 4, transmit FIFO depth (power of two).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- addr  in  ADDR_WIDTH  byte address from the CPU.
- wrData  in  DATA_WIDTH  store data from the CPU.
- wrEnable  in  1  store strobe; a write occurs at the rising edge while high.
- rdData  out  DATA_WIDTH  load data for `addr`; combinational.
- led  out  8  LED register contents.
- txData  out  8  FIFO head byte.
- txValid  out  1  FIFO non-empty.
- txReady  in  1  consumer accepts the head byte.

## Operation
- Address bits [1:0] are ignored; all accesses are whole words.
- Address decode:
  - addr[ADDR_WIDTH-1]=0 selects RAM.
  - addr[ADDR_WIDTH-1]=1 selects I/O.
- RAM access:
  - Word index is addr[log2(RAM_WORDS)+1:2].
  - Upper RAM address bits alias.
  - RAM contents are not reset.
- I/O map, decoded on the offset addr[ADDR_WIDTH-2:0]:
  - 0x0 LED: RW. A write stores wrData[7:0]. A read returns the value zero-extended.
  - 0x4 CYCLE:
    - Read returns the counter.
    - The counter increments every cycle and wraps from 2^32-1 to 0.
    - Any write clears it, so the next value is 0. Clear has priority over increment.
  - 0x8 TXDATA: a write pushes wrData[7:0] into the FIFO. A read returns 0.
  - 0xC TXSTAT:
    - Read returns {29'b0, overflow, full, empty}.
    - Any write clears overflow.
  - Any other I/O offset reads 0; writes to it are ignored.
- FIFO:
  - Pop occurs when txValid and txReady are both high at the edge.
  - A push is accepted if count < TX_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the push is dropped and sticky overflow is set.
  - Read/write pointers wrap modulo TX_DEPTH.
  - count is log2(TX_DEPTH)+1 bits wide.
  - Order is preserved strictly.
- Overflow conflict: if an overflow-setting push and a TXSTAT write occur in the same cycle, overflow stays set. The two cannot coincide on one bus, so this case is unreachable; it is specified for completeness.
- Reset (rst=0, asynchronous) sets:
  - led=0 and the cycle counter to 0.
  - FIFO empty: pointers and count 0.
  - overflow=0, txValid=0.
  - txData=0 while empty.

## Timing
- rdData is combinational from addr and current state; there is zero-cycle load latency.
- Same-cycle read/write: a read of a location being written in the same cycle returns the old value. The new value is visible the cycle after the edge.
- A TXDATA write at edge N raises txValid after edge N if the FIFO was empty.
- txData is the head entry; it is stable while txValid is high and no pop occurs.
- Pop at edge N advances the head. txValid drops after edge N if the FIFO becomes empty.
- CYCLE read in the cycle after reset release returns 0; each subsequent cycle it reads +1.
- Reset asserted mid-transfer discards FIFO contents immediately. txValid falls without waiting for a clock.

## Test plan
- RAM:
  - Write 0xDEADBEEF to 0x0010, then read 0x0010 → 0xDEADBEEF.
  - Read 0x0013 → 0xDEADBEEF (low bits ignored).
  - Read 0x1010 with RAM_WORDS=1024 → 0xDEADBEEF (alias).
- LED and unmapped I/O:
  - Write 0x123456A5 to 0x8000 → led=0xA5, and a read of 0x8000 returns 0x000000A5.
  - Read 0x8010 → 0.
- Cycle counter:
  - Release reset, then sample 0x8004 five cycles apart → difference 5.
  - Write 0x8004 → next read 0.
  - Force the counter to 0xFFFFFFFF → next cycle 0.
- FIFO fill/overflow with txReady=0:
  - Push 0x41..0x45 → STAT after four pushes = 0b010; after the fifth = 0b110.
  - Raise txReady → bytes 0x41,0x42,0x43,0x44 appear in order, then empty.
  - Write TXSTAT → overflow cleared, STAT=0b001.
- Full + simultaneous push/pop:
  - With the FIFO full and txReady=1, push 0x55 → accepted, overflow stays 0, count stays 4.
  - 0x55 emerges last.
- Asynchronous reset:
  - Drive rst=0 mid-cycle with 3 queued bytes and led=0xFF → txValid=0, led=0, counter 0 without a clock edge.
  - After release, STAT=0b001.

Source files
------------

// File: rtl/data_bus_responder.sv
// Data bus responder: decodes CPU byte addresses onto data RAM or MMIO (LED, cycle counter, TX FIFO).
// Latency: reads are combinational (zero cycles); writes commit on the rising clock edge.
// Backpressure: TX FIFO drains on txValid&txReady; a push to a full FIFO without a same-cycle pop is dropped and sets sticky overflow.
module data_bus_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int RAM_WORDS  = 1024,
  parameter int TX_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wrData,
  input  logic                  wrEnable,
  output logic [DATA_WIDTH-1:0] rdData,
  output logic [7:0]            led,
  output logic [7:0]            txData,
  output logic                  txValid,
  input  logic                  txReady
);

  localparam int RAM_AW    = $clog2(RAM_WORDS);
  localparam int TX_AW     = $clog2(TX_DEPTH);
  // I/O word offset covers addr[ADDR_WIDTH-2:2]
  localparam int IO_WORD_W = ADDR_WIDTH - 3;

  localparam logic [IO_WORD_W-1:0] IO_LED    = IO_WORD_W'(0);
  localparam logic [IO_WORD_W-1:0] IO_CYCLE  = IO_WORD_W'(1);
  localparam logic [IO_WORD_W-1:0] IO_TXDATA = IO_WORD_W'(2);
  localparam logic [IO_WORD_W-1:0] IO_TXSTAT = IO_WORD_W'(3);

  // Accesses are whole words, so the byte-lane bits play no part in decode
  logic                 unusedAddrBits;
  logic                 isIo;
  logic [RAM_AW-1:0]    ramIdx;
  logic [IO_WORD_W-1:0] ioWord;

  assign unusedAddrBits = ^addr[1:0];
  assign isIo           = addr[ADDR_WIDTH-1];
  assign ramIdx         = addr[RAM_AW+1:2];
  assign ioWord         = addr[ADDR_WIDTH-2:2];

  logic ramWr;
  logic ledWr;
  logic cycleWr;
  logic txPush;
  logic statWr;

  assign ramWr   = wrEnable & ~isIo;
  assign ledWr   = wrEnable & isIo & (ioWord == IO_LED);
  assign cycleWr = wrEnable & isIo & (ioWord == IO_CYCLE);
  assign txPush  = wrEnable & isIo & (ioWord == IO_TXDATA);
  assign statWr  = wrEnable & isIo & (ioWord == IO_TXSTAT);

  logic [DATA_WIDTH-1:0] ram [RAM_WORDS];
  logic [31:0]           cycleCount;
  logic [7:0]            txMem [TX_DEPTH];
  logic [TX_AW-1:0]      rdPtr;
  logic [TX_AW-1:0]      wrPtr;
  logic [TX_AW:0]        txCount;
  logic                  overflow;

  logic txFull;
  logic txPop;
  logic pushAcc;
  logic pushDrop;

  assign txValid  = (txCount != '0);
  assign txFull   = (txCount == (TX_AW+1)'(TX_DEPTH));
  assign txPop    = txValid & txReady;
  // A pop in the same cycle frees the slot the push needs
  assign pushAcc  = txPush & (~txFull | txPop);
  assign pushDrop = txPush & ~pushAcc;
  // Head byte is forced to zero while empty so stale storage never shows
  assign txData   = txValid ? txMem[rdPtr] : 8'h00;

  // Data RAM store; contents deliberately not reset
  always_ff @(posedge clk) begin
    if (ramWr) begin
      ram[ramIdx] <= wrData;
    end
  end

  // TX FIFO storage; only the pointers need reset
  always_ff @(posedge clk) begin
    if (pushAcc) begin
      txMem[wrPtr] <= wrData[7:0];
    end
  end

  // LED register and free-running cycle counter (clear wins over increment)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led        <= 8'h00;
      cycleCount <= 32'h0;
    end else begin
      if (ledWr) begin
        led <= wrData[7:0];
      end
      if (cycleWr) begin
        cycleCount <= 32'h0;
      end else begin
        cycleCount <= cycleCount + 32'h1;
      end
    end
  end

  // FIFO pointers, occupancy and sticky overflow (set wins over clear)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      txCount  <= '0;
      overflow <= 1'b0;
    end else begin
      if (pushAcc) begin
        wrPtr <= wrPtr + TX_AW'(1);
      end
      if (txPop) begin
        rdPtr <= rdPtr + TX_AW'(1);
      end
      case ({pushAcc, txPop})
        2'b10:   txCount <= txCount + (TX_AW+1)'(1);
        2'b01:   txCount <= txCount - (TX_AW+1)'(1);
        default: txCount <= txCount;
      endcase
      if (pushDrop) begin
        overflow <= 1'b1;
      end else if (statWr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Combinational load path: RAM or I/O register selected by the address
  always_comb begin
    rdData = '0;
    if (!isIo) begin
      rdData = ram[ramIdx];
    end else begin
      case (ioWord)
        IO_LED:    rdData = DATA_WIDTH'(led);
        IO_CYCLE:  rdData = DATA_WIDTH'(cycleCount);
        IO_TXSTAT: rdData = DATA_WIDTH'({overflow, txFull, ~txValid});
        default:   rdData = '0;
      endcase
    end
  end

endmodule
